// File: rtl/barrel_pkg.sv
// ============================================================================
// Module : barrel_pkg
// Brief  : Shared constants and helpers for the barrel scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package barrel_pkg;

    localparam logic BARREL_VER = 1'b0;
    localparam logic BARREL_HOR = 1'b1;

    localparam int SPAWN_PERIOD_DEF = 130_000_000;
    localparam int THROW_CYCLES_DEF = 32_500_000;
    localparam int MAX_SLOTS        = 8;
    localparam int TIMER_W          = 28;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic logic [3:0] popcount(input logic [MAX_SLOTS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_scheduler_if.sv
// ============================================================================
// Module : barrel_scheduler_if
// Brief  : Scheduler <-> barrel unit launch/status bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface barrel_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    logic [NUM_SLOTS-1:0] barrel_done;
    logic [NUM_SLOTS-1:0] barrel_hit;
    logic [NUM_SLOTS-1:0] barrel_start;
    logic [NUM_SLOTS-1:0] barrel_type;

    modport master (
        input  barrel_done,
        input  barrel_hit,
        output barrel_start,
        output barrel_type
    );

    modport slave (
        output barrel_done,
        output barrel_hit,
        input  barrel_start,
        input  barrel_type
    );
endinterface

`default_nettype wire

// File: rtl/barrel_lfsr.sv
// ============================================================================
// Module : barrel_lfsr
// Brief  : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module barrel_lfsr
    import barrel_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    output logic [7:0]      value
);

    logic [7:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= LFSR_SEED;
        end else begin
            r_value <= {r_value[6:0], r_value[7] ^ r_value[5] ^ r_value[4] ^ r_value[3]};
        end
    end

    assign value = r_value;

endmodule

`default_nettype wire

// File: rtl/barrel_scheduler.sv
// ============================================================================
// Module : barrel_scheduler
// Brief  : Periodic Kong throw + launch into the lowest free barrel unit.
//          Define BARREL_LFSR_EN for pseudo-random barrel types.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module barrel_scheduler
    import barrel_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int SPAWN_PERIOD = SPAWN_PERIOD_DEF,
    parameter int THROW_CYCLES = THROW_CYCLES_DEF
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               enable,
    barrel_scheduler_if.master      bus,
    output logic                    kong_throw,
    output logic                    hit,
    output logic [3:0]              busy_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_THROW  = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_HALT   = 3'd4
    } STATE_T;

    localparam logic [TIMER_W-1:0] c_spawn_last = TIMER_W'(SPAWN_PERIOD - 1);
    localparam logic [TIMER_W-1:0] c_throw_last = TIMER_W'(THROW_CYCLES - 1);

    STATE_T                 r_state;
    STATE_T                 w_state_nxt;
    logic [TIMER_W-1:0]     r_timer;
    logic [TIMER_W-1:0]     w_timer_nxt;
    logic                   r_throw;
    logic                   w_throw_nxt;
    logic                   r_hit;
    logic                   w_hit_nxt;
    logic [NUM_SLOTS-1:0]   r_start;
    logic [NUM_SLOTS-1:0]   w_start_nxt;
    logic [NUM_SLOTS-1:0]   r_busy;
    logic [NUM_SLOTS-1:0]   r_type;
    logic [3:0]             r_busy_count;
    logic [NUM_SLOTS-1:0]   w_sel;
    logic                   w_any_free;
    logic                   w_type_bit;

`ifdef BARREL_LFSR_EN
    logic [7:0] w_lfsr;

    barrel_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (w_lfsr)
    );

    assign w_type_bit = w_lfsr[0];
`else
    logic r_toggle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toggle <= 1'b0;
        end else if (|w_start_nxt) begin
            r_toggle <= ~r_toggle;
        end
    end

    assign w_type_bit = r_toggle ? BARREL_HOR : BARREL_VER;
`endif

    // Lowest-numbered free unit, one-hot.
    always_comb begin
        w_sel      = '0;
        w_any_free = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!r_busy[i] && !w_any_free) begin
                w_sel[i]   = 1'b1;
                w_any_free = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_throw_nxt = 1'b0;
        w_hit_nxt   = 1'b0;
        w_start_nxt = '0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else if ((r_state != ST_IDLE) && (|bus.barrel_hit)) begin
            w_state_nxt = ST_HALT;
            w_hit_nxt   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_WAIT;
                    w_timer_nxt = '0;
                end
                ST_WAIT: begin
                    // Timer saturates at the last count until a unit frees up.
                    if (r_timer == c_spawn_last) begin
                        if (w_any_free) begin
                            w_state_nxt = ST_THROW;
                            w_timer_nxt = '0;
                            w_throw_nxt = 1'b1;
                        end
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                ST_THROW: begin
                    if (r_timer == c_throw_last) begin
                        w_state_nxt = ST_LAUNCH;
                        w_timer_nxt = '0;
                        w_start_nxt = w_sel;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                        w_throw_nxt = 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    w_state_nxt = ST_WAIT;
                    w_timer_nxt = '0;
                end
                ST_HALT: begin
                    w_hit_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_throw      <= 1'b0;
            r_hit        <= 1'b0;
            r_start      <= '0;
            r_busy       <= '0;
            r_type       <= '0;
            r_busy_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_throw      <= w_throw_nxt;
            r_hit        <= w_hit_nxt;
            r_start      <= w_start_nxt;
            // Done on a different unit in the launch cycle still clears it.
            r_busy       <= (r_busy & ~bus.barrel_done) | w_start_nxt;
            r_type       <= (r_type & ~w_start_nxt) | (w_start_nxt & {NUM_SLOTS{w_type_bit}});
            r_busy_count <= popcount(MAX_SLOTS'(r_busy));
        end
    end

    assign bus.barrel_start = r_start;
    assign bus.barrel_type  = r_type;
    assign kong_throw       = r_throw;
    assign hit              = r_hit;
    assign busy_count       = r_busy_count;

endmodule

`default_nettype wire

// File: tb/tb_barrel_scheduler.sv
// ============================================================================
// Module : tb_barrel_scheduler
// Brief  : Scoreboard bench for barrel_scheduler (SPAWN=10, THROW=4, 2 slots).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_barrel_scheduler;
    import barrel_pkg::*;

    localparam int NS = 2;
    localparam int SP = 10;
    localparam int TC = 4;

    typedef struct {
        logic [NS-1:0] start;
        logic          typ;
        int            edge_n;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       kong_throw;
    logic       hit;
    logic [3:0] busy_count;

    int   tests;
    int   fails;
    int   cyc;
    int   base;
    exp_t sb[$];

    logic [7:0] m_lfsr;
    logic [7:0] m_prev;

    barrel_scheduler_if #(.NUM_SLOTS(NS)) bus ();

    barrel_scheduler #(
        .NUM_SLOTS    (NS),
        .SPAWN_PERIOD (SP),
        .THROW_CYCLES (TC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .bus        (bus.master),
        .kong_throw (kong_throw),
        .hit        (hit),
        .busy_count (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR; m_prev holds the value seen at the most recent edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns at the falling edge following edge k of the current run.
    task automatic at_edge(input int k);
        while (cyc < base + k + 1) @(negedge clk);
    endtask

    task automatic push(input logic [NS-1:0] s, input logic t, input int e);
        exp_t x;
        x.start  = s;
        x.typ    = t;
        x.edge_n = e;
        sb.push_back(x);
    endtask

    // Monitor: every launch pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (bus.barrel_start != '0) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_launch: got start=%b at edge %0d, expected none",
                         bus.barrel_start, cyc - base - 1);
            end else begin
                exp_t x;
                logic exp_typ;
                int   unit;
                x = sb.pop_front();
                unit = (x.start[1]) ? 1 : 0;
`ifdef BARREL_LFSR_EN
                exp_typ = m_prev[0];
`else
                exp_typ = x.typ;
`endif
                check("launch_start", int'(bus.barrel_start), int'(x.start));
                check("launch_edge", cyc - base - 1, x.edge_n);
                check("launch_type", int'(bus.barrel_type[unit]), int'(exp_typ));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests  = 0;
        fails  = 0;
        cyc    = 0;
        base   = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        bus.barrel_done = '0;
        bus.barrel_hit  = '0;

        repeat (3) @(negedge clk);
        check("rst_start", int'(bus.barrel_start), 0);
        check("rst_type", int'(bus.barrel_type), 0);
        check("rst_kong", int'(kong_throw), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_busy_count", int'(busy_count), 0);
        rst_n = 1'b1;

        // Launch sequence from a cold start.
        @(negedge clk);
        enable = 1'b1;
        base   = cyc;
        push(2'b01, 1'b0, 14);
        push(2'b10, 1'b1, 29);
        at_edge(9);  check("t1_kong_e9", int'(kong_throw), 0);
        at_edge(10); check("t1_kong_e10", int'(kong_throw), 1);
        at_edge(13); check("t1_kong_e13", int'(kong_throw), 1);
        at_edge(14); check("t1_kong_e14", int'(kong_throw), 0);
                     check("t1_busy_e14", int'(busy_count), 0);
        at_edge(15); check("t1_busy_e15", int'(busy_count), 1);
        at_edge(30); check("t1_busy_e30", int'(busy_count), 2);

        // All units busy: spawning stalls until a done frees unit 0.
        at_edge(40); check("t2_kong_e40", int'(kong_throw), 0);
        at_edge(49); check("t2_kong_e49", int'(kong_throw), 0);
        bus.barrel_done = 2'b01;
        push(2'b01, 1'b0, 55);
        at_edge(50); bus.barrel_done = '0;
                     check("t2_kong_e50", int'(kong_throw), 0);
        at_edge(51); check("t2_kong_e51", int'(kong_throw), 1);
                     check("t2_busy_e51", int'(busy_count), 1);
        at_edge(56); check("t2_busy_e56", int'(busy_count), 2);

        // Done on unit 1 coincides with the launch of unit 0.
        at_edge(69); bus.barrel_done = 2'b01;
        at_edge(70); bus.barrel_done = '0;
        push(2'b01, 1'b1, 75);
        push(2'b10, 1'b0, 90);
        at_edge(74); bus.barrel_done = 2'b10;
        at_edge(75); bus.barrel_done = '0;
        at_edge(76); check("t6_busy_e76", int'(busy_count), 1);
        at_edge(77); check("t6_busy_e77", int'(busy_count), 1);
        at_edge(91); check("t6_busy_e91", int'(busy_count), 2);

        // Hit during a throw halts spawning; disable clears it.
        at_edge(99);  bus.barrel_done = 2'b01;
        at_edge(100); bus.barrel_done = '0;
        at_edge(101); check("t3_kong_e101", int'(kong_throw), 1);
        bus.barrel_hit = 2'b10;
        at_edge(102); bus.barrel_hit = '0;
                      check("t3_hit_e102", int'(hit), 1);
                      check("t3_kong_e102", int'(kong_throw), 0);
        at_edge(110); check("t3_hit_e110", int'(hit), 1);
                      check("t3_kong_e110", int'(kong_throw), 0);
        enable = 1'b0;
        at_edge(111); check("t3_hit_e111", int'(hit), 0);
                      check("t3_busy_e111", int'(busy_count), 1);

        // Asynchronous reset in the middle of a throw.
        enable = 1'b1;
        base   = cyc;
        at_edge(11); check("t5_kong_e11", int'(kong_throw), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_kong", int'(kong_throw), 0);
        check("t5_async_busy", int'(busy_count), 0);
        check("t5_async_type", int'(bus.barrel_type), 0);
        check("t5_async_start", int'(bus.barrel_start), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        push(2'b01, 1'b0, 14);
        at_edge(9);  check("t5_kong_e9", int'(kong_throw), 0);
        at_edge(13); check("t5_kong_e13", int'(kong_throw), 1);
        at_edge(15); check("t5_busy_e15", int'(busy_count), 1);

        // Enable dropped mid-throw: throw ends, nothing is launched.
        at_edge(25); check("t7_kong_e25", int'(kong_throw), 1);
        enable = 1'b0;
        at_edge(26); check("t7_kong_e26", int'(kong_throw), 0);
        at_edge(45); check("t7_busy_e45", int'(busy_count), 1);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/barrel_scheduler.md
# barrel_scheduler

Schedules barrel launches from Kong and shares a fixed pool of barrel units among successive throws. Every spawn period, if a unit is free, it runs Kong's throw animation, then pulses the start input of the lowest-numbered free unit and tells that unit what kind of barrel to be (vertical fall or rolling). It tracks which units are busy from their `done` pulses. On any barrel hit it freezes spawning and raises a sticky `hit` for the game-state logic. It sits between the game controller and the instantiated barrel units, including the vertical-fall units.

## Interface
Parameters:
- `NUM_SLOTS`, 4: number of barrel units managed (2..8).
- `SPAWN_PERIOD`, 130_000_000: cycles between launches (2 s at 65 MHz).
- `THROW_CYCLES`, 32_500_000: cycles `kong_throw` is held before a launch.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `enable`, in, 1: game running.
- `barrel_done`, in, NUM_SLOTS: per-unit done pulse.
- `barrel_hit`, in, NUM_SLOTS: per-unit hit flag.
- `barrel_start`, out, NUM_SLOTS: one-hot, one-cycle launch pulse.
- `barrel_type`, out, NUM_SLOTS: per-unit type latched at launch; 0 = vertical, 1 = rolling.
- `kong_throw`, out, 1: throw animation request.
- `hit`, out, 1: sticky hit flag.
- `busy_count`, out, 4: number of busy units.

## Operation
- State machine states:
  - `ST_IDLE`: reached from any state when `enable`=0; a sampled `enable`=1 moves to `ST_WAIT`.
  - `ST_WAIT`: timer cleared on entry, increments each cycle.
    - At timer == SPAWN_PERIOD-1 with a free unit, go to `ST_THROW`.
    - At timer == SPAWN_PERIOD-1 with no free unit, hold the timer at that value (saturate) and stay until a unit is free.
  - `ST_THROW`: `kong_throw`=1; timer counts THROW_CYCLES, then go to `ST_LAUNCH`.
  - `ST_LAUNCH`: one cycle; `barrel_start[i]`=1 for i = lowest free unit. `barrel_type[i]` and `busy[i]` are set in the same cycle, then go to `ST_WAIT`.
  - `ST_HALT`: `hit`=1, no launches; leaves only to `ST_IDLE` when `enable`=0.
- Priority:
  - `enable`=0 overrides everything.
  - Otherwise any `barrel_hit` bit high, in any state except `ST_IDLE`, goes to `ST_HALT` next cycle.
  - `kong_throw` and `barrel_start` are suppressed in that same cycle.
- The selected unit cannot become busy between selection and launch, because only this block sets busy bits.
- Busy tracking is independent of state:
  - `busy[i]` clears on `barrel_done[i]` and is set only by a launch.
  - A launch of unit i and a done on unit j≠i in the same cycle both take effect.
  - A done on a unit that is not busy is ignored.
  - Busy bits persist through `ST_IDLE` and `ST_HALT`.
- `busy_count` = popcount of the busy bits; it is registered and updates the cycle after a busy bit changes.
- Type selection:
  - With the LFSR option: `lfsr[0]` at launch.
  - Otherwise: a toggle bit, 0 on reset, inverted after each launch (types run 0,1,0,1...).

## Timing
- All outputs are registered. On `rst_n`=0, immediately and asynchronously: all outputs 0, busy bits 0, timer 0, toggle 0, LFSR = 8'hA5, state `ST_IDLE`.
- With `enable` sampled high at edge 0:
  - `kong_throw` is high after edges SPAWN_PERIOD .. SPAWN_PERIOD+THROW_CYCLES-1.
  - `barrel_start` is high after edge SPAWN_PERIOD+THROW_CYCLES.
  - The next period's timer starts at the following edge.
- `enable` dropping mid-throw: `kong_throw` is 0 after the next edge, and no launch occurs.
- Timer is 28 bits, sized from the default parameters.

## Configuration
- `BARREL_LFSR_EN` defined: an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seed 8'hA5, advances every cycle outside reset; pseudo-random types.
- `BARREL_LFSR_EN` undefined: no LFSR is instantiated; types strictly alternate starting with 0.

## Structure
- `barrel_pkg` holds:
  - the `BARREL_VER`/`BARREL_HOR` type constants;
  - the `SPAWN_PERIOD` and `THROW_CYCLES` defaults;
  - `MAX_SLOTS`=8.
- The `STATE_T` enum is local to the module.
- One sub-module: `barrel_lfsr` (ports `clk`, `rst_n`, 8-bit `value`), instantiated only under `BARREL_LFSR_EN`.

## Test plan
Benches use SPAWN_PERIOD=10, THROW_CYCLES=4, NUM_SLOTS=2.
1. Reset, then `enable`=1 at edge 0 -> `kong_throw` high over edges 10–13; `barrel_start`=2'b01 at edge 14; `busy_count`=1 at edge 15; second launch `barrel_start`=2'b10 at edge 29.
2. Both units busy, no done -> no `kong_throw` after edge 39. `barrel_done`=2'b01 pulse at edge 50 -> `kong_throw` starts at edge 51; `barrel_start`=2'b01 at edge 55.
3. `barrel_hit`=2'b10 during `ST_THROW` -> next edge: `hit`=1, `kong_throw`=0, no `barrel_start` afterwards. `enable`=0 -> `hit`=0 next edge.
4. Macro off: four launches yield types 0,1,0,1. Macro on: types match a reference LFSR model seeded 8'hA5, sampled at each launch edge.
5. `rst_n`=0 mid-throw -> all outputs 0 asynchronously, before the next edge. After release and `enable`, the first `barrel_start` is a full 14 edges later.
6. `barrel_done[1]` in the same cycle as the launch of unit 0 -> busy bits become 2'b01; `busy_count` is 1 on the next edge.
